// File: rtl/db_ram_pkg.sv
// Shared definitions for the deblocking-filter single-port RAM: clear FSM
// encoding and lane-count helpers.
package db_ram_pkg;

    typedef enum logic [0:0] {
        DB_RAM_IDLE  = 1'b0,
        DB_RAM_CLEAR = 1'b1
    } db_ram_state_e;

    function automatic int db_ram_lanes(input int word_w, input int lane_w);
        return word_w / lane_w;
    endfunction

    // Word must split into whole lanes, otherwise the top bits have no enable.
    function automatic bit db_ram_width_ok(input int word_w, input int lane_w);
        return (lane_w > 0) && (word_w % lane_w == 0);
    endfunction

endpackage

// File: rtl/ram_1p_bw.sv
// Pure single-port storage array with per-lane active-low write enables and a
// registered read port. No reset: contents and read register power up unknown.
module ram_1p_bw #(
    parameter int Word_Width = 16,
    parameter int Addr_Width = 8,
    parameter int Lane_Width = 8
) (
    input  logic                             clk,
    input  logic                             cen,
    input  logic                             wen,
    input  logic [Word_Width/Lane_Width-1:0] bwen,
    input  logic [Addr_Width-1:0]            addr,
    input  logic [Word_Width-1:0]            wdata,
    output logic [Word_Width-1:0]            rdata
);
    localparam int Lanes = Word_Width / Lane_Width;
    localparam int Depth = 1 << Addr_Width;

    logic [Lanes-1:0][Lane_Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                for (int k = 0; k < Lanes; k++) begin
                    if (!bwen[k]) mem[addr][k] <= wdata[k*Lane_Width +: Lane_Width];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/db_ram_1p_bw_init.sv
// Deblocking-filter single-port RAM with byte-lane writes and a clear engine
// that fills every word with Init_Value after reset or on clr_i.
module db_ram_1p_bw_init
    import db_ram_pkg::*;
#(
    parameter int                    Word_Width    = 16,
    parameter int                    Addr_Width    = 8,
    parameter int                    Lane_Width    = 8,
    parameter logic [Word_Width-1:0] Init_Value    = '0,
    parameter bit                    Init_On_Reset = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    output logic                             busy_o,
    output logic                             done_o,
    input  logic                             cen_i,
    input  logic                             oen_i,
    input  logic                             wen_i,
    input  logic [Word_Width/Lane_Width-1:0] bwen_i,
    input  logic [Addr_Width-1:0]            addr_i,
    input  logic [Word_Width-1:0]            data_i,
    output logic [Word_Width-1:0]            data_o
);
    localparam int Lanes = db_ram_lanes(Word_Width, Lane_Width);

    if (!db_ram_width_ok(Word_Width, Lane_Width)) begin : g_bad_width
        $error("db_ram_1p_bw_init: Word_Width must be a multiple of Lane_Width");
    end

    db_ram_state_e         state, state_n;
    logic [Addr_Width-1:0] cnt, cnt_n;
    logic                  done_n;
    logic                  rd_vld;

    logic                  m_cen, m_wen;
    logic [Lanes-1:0]      m_bwen;
    logic [Addr_Width-1:0] m_addr;
    logic [Word_Width-1:0] m_wdata, m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= Init_On_Reset ? DB_RAM_CLEAR : DB_RAM_IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_o <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            DB_RAM_IDLE: begin
                if (clr_i) begin
                    state_n = DB_RAM_CLEAR;
                    cnt_n   = '0;
                end
            end
            DB_RAM_CLEAR: begin
                cnt_n = cnt + Addr_Width'(1);
                if (cnt == '1) begin
                    state_n = DB_RAM_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = DB_RAM_IDLE;
        endcase
    end

    assign busy_o = (state == DB_RAM_CLEAR);

    // Clear owns the array while busy; nothing touches it during reset.
    always_comb begin
        m_cen   = 1'b1;
        m_wen   = 1'b1;
        m_bwen  = '1;
        m_addr  = addr_i;
        m_wdata = data_i;
        if (rst) begin
            m_cen = 1'b1;
        end else if (state == DB_RAM_CLEAR) begin
            m_cen   = 1'b0;
            m_wen   = 1'b0;
            m_bwen  = '0;
            m_addr  = cnt;
            m_wdata = Init_Value;
        end else begin
            m_cen  = cen_i;
            m_wen  = wen_i;
            m_bwen = bwen_i;
        end
    end

    // The array has no reset, so a valid flag makes the read register look
    // zero until the first user read after reset.
    always_ff @(posedge clk) begin
        if (rst)                                          rd_vld <= 1'b0;
        else if (state == DB_RAM_IDLE && !cen_i && wen_i) rd_vld <= 1'b1;
    end

    assign data_o = (oen_i || !rd_vld) ? '0 : m_rdata;

    ram_1p_bw #(
        .Word_Width (Word_Width),
        .Addr_Width (Addr_Width),
        .Lane_Width (Lane_Width)
    ) u_ram (
        .clk   (clk),
        .cen   (m_cen),
        .wen   (m_wen),
        .bwen  (m_bwen),
        .addr  (m_addr),
        .wdata (m_wdata),
        .rdata (m_rdata)
    );

endmodule

// File: tb/tb_db_ram_1p_bw_init.sv
// Self-checking bench for db_ram_1p_bw_init: directed vector table, clear and
// reset-abort sequences, then random traffic against a behavioural model.
module tb_db_ram_1p_bw_init;
    localparam int DEPTH = 256;
    localparam logic [15:0] INIT = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_i, cen_i, oen_i, wen_i, busy_o, done_o;
    logic [1:0]  bwen_i;
    logic [7:0]  addr_i;
    logic [15:0] data_i, data_o;

    db_ram_1p_bw_init #(
        .Word_Width(16), .Addr_Width(8), .Lane_Width(8),
        .Init_Value(INIT), .Init_On_Reset(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .clr_i(clr_i), .busy_o(busy_o), .done_o(done_o),
        .cen_i(cen_i), .oen_i(oen_i), .wen_i(wen_i), .bwen_i(bwen_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: memory array, read register, clear cycles remaining.
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_rd;
    int          m_left;
    bit          m_done;

    typedef struct {
        bit          ce, we, oe;
        logic [1:0]  bw;
        logic [7:0]  addr;
        logic [15:0] data;
        bit          chk;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit ce, input bit we, input bit oe,
                       input logic [1:0] bw, input logic [7:0] a, input logic [15:0] d);
        rst = r; clr_i = c; cen_i = ce; wen_i = we; oen_i = oe;
        bwen_i = bw; addr_i = a; data_i = d;
        @(posedge clk);
        m_done = 1'b0;
        if (r) begin
            m_left = DEPTH;
            m_rd   = 16'h0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = INIT;
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            if (!ce) begin
                if (!we) begin
                    for (int k = 0; k < 2; k++)
                        if (!bw[k]) m_mem[a][k*8 +: 8] = d[k*8 +: 8];
                end else begin
                    m_rd = m_mem[a];
                end
            end
            if (c) m_left = DEPTH;
        end
        #1;
        check("busy", {31'b0, busy_o}, {31'b0, m_left > 0});
        check("done", {31'b0, done_o}, {31'b0, m_done});
        check("data", {16'b0, data_o}, {16'b0, oe ? 16'h0 : m_rd});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0000);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, a, 16'h0000);
    endtask

    initial begin
        int bc, dn;
        bit seen;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
        m_rd = 16'h0; m_left = 0; m_done = 1'b0;

        // Reset, then the automatic clear.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0);
        check("rst_data_o", {16'b0, data_o}, 32'h0);
        bc = busy_o ? 1 : 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            idle();
            if (done_o) seen = 1'b1;
            else if (busy_o) bc++;
        end
        check("init_done_seen", {31'b0, seen}, 32'd1);
        check("init_busy_cycles", bc, DEPTH);

        vt[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h12, 16'hA55A, 1'b0, 16'h0000};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 2'b10, 8'h12, 16'hFFFF, 1'b0, 16'h0000};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h12, 16'h0000, 1'b1, 16'hA5FF};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 2'b11, 8'h12, 16'h0000, 1'b1, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0000, 1'b1, 16'hA5FF};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0000, 1'b1, 16'h0000};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h7F, 16'h0000, 1'b1, 16'h0000};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'hFF, 16'h0000, 1'b1, 16'h0000};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'b11, 8'h20, 16'h1111, 1'b0, 16'h0000};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h20, 16'h0000, 1'b1, 16'h0000};
        vt[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h12, 16'h5555, 1'b0, 16'h0000};
        vt[11] = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0000, 1'b1, 16'h0000};
        vt[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h12, 16'h0000, 1'b1, 16'h5555};
        vt[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 8'h12, 16'h00AA, 1'b0, 16'h0000};
        vt[14] = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h12, 16'h0000, 1'b1, 16'h0055};
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, vt[i].ce, vt[i].we, vt[i].oe, vt[i].bw, vt[i].addr, vt[i].data);
            if (vt[i].chk) check($sformatf("vec%0d", i), {16'b0, data_o}, {16'b0, vt[i].exp});
        end

        // Clear with a same-cycle write; a busy write and a second clr_i are ignored.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h12, 16'hBEEF);
        bc = busy_o ? 1 : 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (i == 10)      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h40, 16'h1234);
            else if (i == 50) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0);
            else              idle();
            if (done_o) seen = 1'b1;
            else if (busy_o) bc++;
        end
        check("clr_done_seen", {31'b0, seen}, 32'd1);
        check("clr_busy_cycles", bc, DEPTH);
        rd(8'h40);
        check("clr_addr40", {16'b0, data_o}, {16'b0, INIT});
        rd(8'h12);
        check("clr_addr12", {16'b0, data_o}, {16'b0, INIT});

        // Reset 100 cycles into a clear restarts it from address 0.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h05, 16'h7777);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0);
        for (int i = 0; i < 99; i++) idle();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 16'h0);
        bc = busy_o ? 1 : 0; dn = 0;
        for (int i = 0; i < 300; i++) begin
            idle();
            if (busy_o) bc++;
            if (done_o) dn++;
        end
        check("abort_busy_cycles", bc, DEPTH);
        check("abort_done_pulses", dn, 1);
        rd(8'h05);
        check("abort_addr05", {16'b0, data_o}, {16'b0, INIT});

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 1499) == 0), ($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 5) == 0), 2'($urandom), 8'($urandom_range(0, 15)),
                16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/db_ram_1p_bw_init.md
# db_ram_1p_bw_init

Parametrised single-port SRAM for the deblocking filter: Word_Width × 2^Addr_Width storage with per-lane byte-write enables and a built-in clear engine that fills the array with a constant after reset or on request. It replaces the fixed 16×256 single-port wrappers in the deblocking datapath. Filter state buffers no longer need an external zero-fill pass at the start of each LCU row or frame.

## Interface
- Word_Width, 16, data word width in bits; must be a multiple of Lane_Width
- Addr_Width, 8, address width; Depth = 2^Addr_Width
- Lane_Width, 8, bits per write lane; Lanes = Word_Width/Lane_Width
- Init_Value, 0, Word_Width-bit constant written by the clear engine
- Init_On_Reset, 1, 1: clear runs automatically after reset; 0: only on clr_i
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr_i  in  1  start-clear request (single-cycle pulse or level), sampled only when idle
- busy_o  out  1  clear in progress; user accesses ignored while high
- done_o  out  1  one-cycle pulse, cycle after last clear write
- cen_i  in  1  chip enable, active-low
- oen_i  in  1  output enable, active-low
- wen_i  in  1  write enable, active-low (0 = write, 1 = read)
- bwen_i  in  Lanes  per-lane write enable, active-low, bit k covers data bits [k*Lane_Width +: Lane_Width]
- addr_i  in  Addr_Width  word address
- data_i  in  Word_Width  write data
- data_o  out  Word_Width  read data

## Operation
- States: IDLE, CLEAR. Clear counter cnt is Addr_Width bits.
- Reset: state ← CLEAR if Init_On_Reset else IDLE; cnt ← 0; read register ← 0; done_o ← 0.
- Reset values of outputs: busy_o = Init_On_Reset, done_o = 0, data_o = 0.
- IDLE with clr_i=1: → CLEAR, cnt ← 0. A user access in the same cycle is still performed.
- CLEAR: every cycle, write Init_Value to address cnt with all lanes enabled, then cnt ← cnt+1.
  - When cnt = Depth−1: → IDLE, done_o = 1 next cycle.
  - A clear takes exactly Depth cycles.
  - cen_i, wen_i, bwen_i, addr_i and data_i are ignored; the read register holds.
  - clr_i is ignored.
- busy_o = (state == CLEAR), decoded from the state register.
- User write (IDLE, cen_i=0, wen_i=0): lane k is updated only if bwen_i[k]=0. bwen_i all-ones is a no-op write. The read register is unchanged; there is no write-through.
- User read (IDLE, cen_i=0, wen_i=1): mem[addr_i] is loaded into the read register.
- cen_i=1: no access; the read register holds.
- data_o = oen_i ? 0 : read register. Gating is combinational and does not disturb the register.
- rst during CLEAR aborts the clear.
  - Init_On_Reset=1: the clear restarts at address 0.
  - Init_On_Reset=0: returns to IDLE, and the array contents are undefined (partially cleared).
- Memory contents are not reset by rst except through the clear engine.

## Timing
- Read latency 1: a request at edge N gives data valid after edge N+1. It is held until the next read.
- Write is committed at the edge where it is sampled. A read of the same address at edge N+1 returns the new data.
- Clear request at edge N: busy_o=1 from N to N+Depth; writes to addresses 0..Depth−1 at edges N+1..N+Depth; done_o high for one cycle after edge N+Depth.
- The first user access is accepted at edge N+Depth+1, the same cycle done_o is high.
- After reset release with Init_On_Reset=1: busy_o is high for Depth cycles, then done_o pulses.
- No combinational path from any input to busy_o or done_o. data_o depends combinationally only on oen_i.

## Structure
- Shared package db_ram_pkg: state encoding (DB_RAM_IDLE, DB_RAM_CLEAR) and the Lanes-derivation function. It also holds a compile-time check that Word_Width is a multiple of Lane_Width.
- Sub-module ram_1p_bw is the pure storage array. It carries the same cen/wen/bwen/addr/data ports and a registered read, with no reset.
- The top level holds the clear FSM, cnt and the port mux between clear and user. It also holds the oen_i gating.

## Test plan
- Reset with Init_On_Reset=1 and Init_Value=16'h0000: busy_o=1 for 256 cycles, done_o pulses once. Reading 0x00, 0x7F and 0xFF then returns 16'h0000.
- Write 16'hA55A to 0x12 with bwen_i=2'b00, then write 16'hFFFF to 0x12 with bwen_i=2'b10. A read of 0x12 returns 16'hA5FF on the cycle after the read request.
- With oen_i=1, read 0x12: data_o=0. Drop oen_i without a new access: data_o=16'hA5FF.
- Pulse clr_i, and attempt a write of 16'h1234 to 0x40 while busy_o=1: the write is dropped. After done_o, reading 0x40 returns Init_Value and reading 0x12 returns Init_Value.
- Assert rst at clear cycle 100 (Init_On_Reset=1): the clear restarts, busy_o stays high 256 more cycles, and done_o pulses exactly once.
- Pulse clr_i again while busy_o=1: no extra cycles. Write in the same cycle as clr_i from IDLE: the write completes, then is overwritten by the clear.
